g2b_sync_decoder: RTL and testbench
===================================

# g2b_sync_decoder

Receive-side counterpart of the binary-to-Gray converter: it samples a Gray-coded count bus from a foreign clock domain, synchronizes it through two flops, converts it back to binary and reports per-cycle step information. It sits at the read end of any Gray-coded pointer or counter crossing, such as FIFO pointers and position counters. It also polices the Gray single-bit-step rule and flags any sample where more than one bit moved at once.

## Interface
- WIDTH, 4, width of the Gray input and of the binary/delta outputs (≥2)
- CNT_W, 8, width of the saturating error counter
- clk  in  1  sole clock; all flops rising-edge
- rst  in  1  asynchronous, active-high reset
- gray_in  in  WIDTH  Gray-coded count, asynchronous to clk
- err_clr  in  1  synchronous clear of step_err and err_count
- binary  out  WIDTH  registered decoded count
- valid  out  1  high once binary holds a genuine sample
- changed  out  1  one-cycle pulse when binary takes a new value
- delta  out  WIDTH  binary_new − binary_old, modulo 2^WIDTH
- step_err  out  1  sticky flag: a Gray multi-bit step was seen
- err_count  out  CNT_W  number of multi-bit steps, saturating at 2^CNT_W−1

## Operation
- Pipeline per edge: s1 ← gray_in; s2 ← s1; s3 ← s2.
- s1/s2 form the synchronizer. s3 is the previous synchronized sample.
- Decode G2B(g): b[WIDTH−1] = g[WIDTH−1]; b[i] = b[i+1] ^ g[i] for i = WIDTH−2 down to 0.
- binary ← G2B(s2), so binary always equals G2B(s3).
- Fill counter fc (2 bits): 0→1→2→3, saturates at 3. valid ← (fc == 2) | valid, so valid rises at the 3rd edge after reset release.
- Compare stage, enabled only while valid = 1 before the edge:
  - changed ← (s2 != s3)
  - delta ← G2B(s2) − G2B(s3), modulo 2^WIDTH; 0 when unchanged
  - multi = popcount(s2 ^ s3) > 1
- While valid = 0: changed ← 0, delta ← 0, multi ignored.
- Error tracking:
  - multi = 1 → step_err ← 1; err_count increments, holding at all-ones.
  - err_clr = 1 with multi = 0 → step_err ← 0, err_count ← 0.
  - err_clr = 1 with multi = 1 in the same cycle → set wins: step_err = 1, err_count = 1.
- Wrap-around is natural modulo arithmetic. Gray 100…0 → 000…0 yields delta = 1 with no error.
- No handshake; outputs update every cycle.

## Timing
- Reset (async assert, immediate): s1, s2, s3, binary, fc, valid, changed, delta, step_err and err_count all 0.
- Latency: a gray_in value captured at edge k appears on binary after edge k+2 (3 edges total including capture).
- changed and delta coincide with the binary update they describe.
- valid is low after edges 1–2 following release and high from edge 3 onward.
- changed, delta and step_err cannot assert before edge 4.
- Reset asserted mid-operation clears everything asynchronously. The fill sequence restarts, and no stale comparison may produce changed or step_err after release.
- err_clr acts at the edge where it is sampled; step_err reads 0 on the following cycle.

## Test plan
- Reset/fill: hold gray_in = 1010, assert rst → all outputs 0. Release → valid = 1 and binary = 1100 after 3rd edge; changed = 0 and delta = 0 throughout.
- Count up: after fill, drive gray 0000, 0001, 0011, 0010, 0110, one per cycle → binary 0, 1, 2, 3, 4 with a 3-edge lag; changed = 1 and delta = 0001 on each step; step_err = 0.
- Wrap and count down: gray 1000 → 0000 → binary 1111 → 0000, delta = 0001. Then gray 0010 → 0011 → binary 0011 → 0010, delta = 1111, no error.
- Multi-bit step: gray 0000 → 0011 → binary 0010, delta = 0010, changed = 1, step_err = 1, err_count = 1. Step_err stays high through later clean steps.
- Error clear: err_clr pulse alone → step_err = 0 and err_count = 0 next cycle. err_clr coincident with a new multi-bit step → step_err = 1 and err_count = 1. Drive 2^CNT_W+2 bad steps → err_count stays at all-ones.
- Mid-run reset: assert rst asynchronously between edges while counting → outputs 0 immediately. After release, valid is low for 2 edges, and no changed or step_err pulse appears from pre-reset data.

Source files
------------

// File: rtl/g2b_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : g2b_sync_decoder                                                 |
// | Purpose  : Read-side end of a Gray-coded counter crossing. Samples a Gray   |
// |            bus from a foreign clock domain through a two-flop synchronizer, |
// |            decodes it to binary, reports the per-cycle step (changed/delta) |
// |            and polices the Gray single-bit-step rule.                       |
// | Ports    : clk        - sole clock, rising edge                             |
// |            rst        - asynchronous active-high reset                      |
// |            gray_in    - Gray-coded count, asynchronous to clk               |
// |            err_clr    - synchronous clear of step_err / err_count           |
// |            binary     - registered decoded count                            |
// |            valid      - binary holds a genuine sample                       |
// |            changed    - one-cycle pulse when binary takes a new value       |
// |            delta      - binary_new - binary_old, modulo 2^WIDTH             |
// |            step_err   - sticky multi-bit-step flag                          |
// |            err_count  - saturating count of multi-bit steps                 |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module g2b_sync_decoder #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clr,
   output logic [WIDTH-1:0] binary,
   output logic             valid,
   output logic             changed,
   output logic [WIDTH-1:0] delta,
   output logic             step_err,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [WIDTH-1:0] c_one_w   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_one_cnt = {{(CNT_W-1){1'b0}}, 1'b1};

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int i = WIDTH-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_s3;
   logic [WIDTH-1:0] r_binary;
   logic [1:0]       r_fc;
   logic             r_valid;
   logic             r_changed;
   logic [WIDTH-1:0] r_delta;
   logic             r_step_err;
   logic [CNT_W-1:0] r_err_count;

   logic [WIDTH-1:0] w_bin_new;
   logic [WIDTH-1:0] w_bin_old;
   logic [WIDTH-1:0] w_diff;
   logic             w_multi;

   assign w_bin_new = g2b(r_s2);
   assign w_bin_old = g2b(r_s3);
   assign w_diff    = r_s2 ^ r_s3;
   // More than one bit set <=> clearing the lowest set bit leaves something.
   // Gated by valid so samples from the fill phase never raise an error.
   assign w_multi   = r_valid & (|(w_diff & (w_diff - c_one_w)));

   // Synchronizer, history stage, decode and fill tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_s3     <= '0;
         r_binary <= '0;
         r_fc     <= 2'd0;
         r_valid  <= 1'b0;
      end else begin
         r_s1     <= gray_in;
         r_s2     <= r_s1;
         r_s3     <= r_s2;
         r_binary <= w_bin_new;
         if (r_fc != 2'd3) begin
            r_fc <= r_fc + 2'd1;
         end
         r_valid  <= (r_fc == 2'd2) | r_valid;
      end
   end

   // Compare stage: only meaningful once s3 holds a real sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_changed <= 1'b0;
         r_delta   <= '0;
      end else begin
         r_changed <= r_valid & (r_s2 != r_s3);
         r_delta   <= r_valid ? (w_bin_new - w_bin_old) : '0;
      end
   end

   // Error tracking: a new error beats a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step_err  <= 1'b0;
         r_err_count <= '0;
      end else if (w_multi) begin
         r_step_err <= 1'b1;
         if (err_clr) begin
            r_err_count <= c_one_cnt;
         end else if (!(&r_err_count)) begin
            r_err_count <= r_err_count + c_one_cnt;
         end
      end else if (err_clr) begin
         r_step_err  <= 1'b0;
         r_err_count <= '0;
      end
   end

   assign binary    = r_binary;
   assign valid     = r_valid;
   assign changed   = r_changed;
   assign delta     = r_delta;
   assign step_err  = r_step_err;
   assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_g2b_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_g2b_sync_decoder                                              |
// | Purpose  : Self-checking bench for g2b_sync_decoder. Expected outputs are   |
// |            queued when a Gray value is driven and compared when the DUT     |
// |            presents the matching sample.                                    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_g2b_sync_decoder;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] gray_in;
   logic             err_clr;
   logic [WIDTH-1:0] binary;
   logic             valid;
   logic             changed;
   logic [WIDTH-1:0] delta;
   logic             step_err;
   logic [CNT_W-1:0] err_count;

   g2b_sync_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .err_clr   (err_clr),
      .binary    (binary),
      .valid     (valid),
      .changed   (changed),
      .delta     (delta),
      .step_err  (step_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] bin;
      logic             vld;
      logic             chg;
      logic [WIDTH-1:0] dlt;
      logic             mul;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_drv;
   logic [WIDTH-1:0] prev_g;
   logic m_err;
   int   m_cnt;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
      end
   endtask

   // Binary value of a Gray code: XOR of all right shifts of the code.
   function automatic logic [WIDTH-1:0] ref_g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] b2g(input int v);
      logic [WIDTH-1:0] b;
      b = v[WIDTH-1:0];
      return b ^ (b >> 1);
   endfunction

   // Restart of the model after reset release: the first two edges present
   // the zeroed pipeline with valid low.
   task automatic init_model();
      exp_t e;
      q.delete();
      e.bin = '0; e.vld = 1'b0; e.chg = 1'b0; e.dlt = '0; e.mul = 1'b0;
      q.push_back(e);
      q.push_back(e);
      n_drv  = 0;
      prev_g = '0;
      m_err  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_binary"},   32'(binary),    32'd0);
      check({tag, "_valid"},    32'(valid),     32'd0);
      check({tag, "_changed"},  32'(changed),   32'd0);
      check({tag, "_delta"},    32'(delta),     32'd0);
      check({tag, "_step_err"}, 32'(step_err),  32'd0);
      check({tag, "_err_cnt"},  32'(err_count), 32'd0);
   endtask

   // Called at a negedge: drive one sample, check the edge, return at next negedge.
   task automatic cycle(input logic [WIDTH-1:0] g, input logic clr);
      exp_t e;
      bit   cmp_on;
      gray_in = g;
      err_clr = clr;
      n_drv++;
      // Sample n reaches binary at edge n+2; comparison is live from sample 2.
      cmp_on = (n_drv >= 2);
      e.bin  = ref_g2b(g);
      e.vld  = 1'b1;
      e.chg  = cmp_on && (g != prev_g);
      e.dlt  = cmp_on ? ref_g2b(g) - ref_g2b(prev_g) : '0;
      e.mul  = cmp_on && ($countones(g ^ prev_g) > 1);
      prev_g = g;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         if (e.mul) begin
            m_err = 1'b1;
            if (clr) m_cnt = 1;
            else if (m_cnt < CNT_MAX) m_cnt++;
         end else if (clr) begin
            m_err = 1'b0;
            m_cnt = 0;
         end
         check("binary",    32'(binary),    32'(e.bin));
         check("valid",     32'(valid),     32'(e.vld));
         check("changed",   32'(changed),   32'(e.chg));
         check("delta",     32'(delta),     32'(e.dlt));
         check("step_err",  32'(step_err),  32'(m_err));
         check("err_count", 32'(err_count), 32'(m_cnt));
      end
      @(negedge clk);
   endtask

   // Asynchronous reset between edges while running.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      init_model();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      gray_in = 4'b1010;
      err_clr = 1'b0;
      @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      init_model();

      // Fill with a constant 1010 input: binary 1100 from the third edge.
      for (int i = 0; i < 5; i++) cycle(4'b1010, 1'b0);

      // Count up 12..36: through 1000 -> 0000 wrap and 0000..0110.
      for (int i = 12; i <= 36; i++) cycle(b2g(i), 1'b0);

      // Count down 4 -> 0 -> 15 -> 13, then up again to 3.
      for (int i = 4; i >= -3; i--) cycle(b2g(i), 1'b0);
      for (int i = -2; i <= 3; i++) cycle(b2g(i), 1'b0);
      for (int i = 3; i >= 0; i--) cycle(b2g(i), 1'b0);

      // Multi-bit step 0000 -> 0011, then clean steps keep step_err sticky.
      cycle(4'b0000, 1'b0);
      cycle(4'b0011, 1'b0);
      cycle(4'b0010, 1'b0);
      cycle(4'b0110, 1'b0);
      for (int i = 0; i < 3; i++) cycle(4'b0110, 1'b0);

      // Clear pulse alone.
      cycle(4'b0110, 1'b1);
      cycle(4'b0110, 1'b0);
      cycle(4'b0110, 1'b0);

      // Clear coincident with a multi-bit step reaching the compare stage.
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b0);

      // 2^CNT_W + 2 bad steps: counter must saturate.
      for (int i = 0; i < (1 << CNT_W) + 2; i++) cycle((i % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);

      // Count, reset mid-run, continue with a jump that must not be flagged.
      for (int i = 0; i < 6; i++) cycle(b2g(i), 1'b0);
      mid_reset();
      for (int i = 9; i < 16; i++) cycle(b2g(i), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
